// File: rtl/db_b3chk_sched_if.sv
// Configuration, checker-side and result signals of the B3/PRBS checker scheduler.
interface db_b3chk_sched_if #(
  parameter int NCH  = 4,
  parameter int CHW  = 2,
  parameter int ERRW = 16,
  parameter int FRMW = 8
);
  logic            cfgen;
  logic [NCH-1:0]  cfgchmask;
  logic [FRMW-1:0] cfgsettle;
  logic [FRMW-1:0] cfgdwell;
  logic [15:0]     cfgtmo;
  logic            ichkerr;
  logic            ichksyn;
  logic [CHW-1:0]  osel;
  logic            ochkrst;
  logic            obusy;
  logic            ordone;
  logic [CHW-1:0]  orch;
  logic [ERRW-1:0] orerr;
  logic            orlos;
  logic [2:0]      dbg_state;

  // Result handshake: ordone is a one-cycle valid with no ready (the sink must
  // always accept); orch/orerr/orlos are meaningful only while ordone=1.
  modport master (
    output cfgen, cfgchmask, cfgsettle, cfgdwell, cfgtmo, ichkerr, ichksyn,
    input  osel, ochkrst, obusy, ordone, orch, orerr, orlos, dbg_state
  );

  modport slave (
    input  cfgen, cfgchmask, cfgsettle, cfgdwell, cfgtmo, ichkerr, ichksyn,
    output osel, ochkrst, obusy, ordone, orch, orerr, orlos, dbg_state
  );
endinterface

// File: rtl/db_b3chk_sched.sv
// Round-robin scheduler time-sharing one B3/PRBS checker across NCH channels:
// select, clear, settle, measure over sync pulses, then report one record.
module db_b3chk_sched #(
  parameter int NCH  = 4,
  parameter int CHW  = 2,
  parameter int ERRW = 16,
  parameter int FRMW = 8
) (
  input logic             clk,
  input logic             rst,
  db_b3chk_sched_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SELECT  = 3'd1,
    SETTLE  = 3'd2,
    MEASURE = 3'd3,
    REPORT  = 3'd4
  } state_t;

  state_t          state, nxt;
  logic [CHW-1:0]  osel_q, last_q, sel_pick;
  logic [FRMW-1:0] syn_cnt, syn_d, syn_next, dwell_eff;
  logic [ERRW-1:0] err_cnt, err_d, err_inc;
  logic [15:0]     tmo_cnt, tmo_d, tmo_next;
  logic            tmo_hit, los, scan_ok;
  logic            ochkrst_q, ordone_q, obusy_q, orlos_q;
  logic [CHW-1:0]  orch_q;
  logic [ERRW-1:0] orerr_q;

  assign scan_ok   = bus.cfgen && (bus.cfgchmask != '0);
  assign dwell_eff = (bus.cfgdwell == '0) ? FRMW'(1) : bus.cfgdwell;
  assign syn_next  = syn_cnt + FRMW'(1);
  assign err_inc   = (err_cnt == '1) ? err_cnt : err_cnt + ERRW'(1);
  // Cycles since the last sync (or since SELECT); a sync cycle never times out.
  assign tmo_next  = bus.ichksyn ? 16'd0 :
                     ((tmo_cnt == 16'hffff) ? tmo_cnt : tmo_cnt + 16'd1);
  assign tmo_hit   = (bus.cfgtmo != 16'd0) && !bus.ichksyn && (tmo_next >= bus.cfgtmo);

  // First enabled channel after last_q, wrapping; descending loop so the
  // nearest candidate is assigned last.
  always_comb begin
    sel_pick = last_q;
    for (int i = NCH; i >= 1; i--) begin
      int idx;
      idx = (int'(last_q) + i) % NCH;
      if (((bus.cfgchmask >> idx) & NCH'(1)) != '0) sel_pick = CHW'(idx);
    end
  end

  always_comb begin
    nxt   = state;
    syn_d = syn_cnt;
    err_d = err_cnt;
    tmo_d = tmo_cnt;
    los   = 1'b0;
    case (state)
      IDLE: begin
        if (scan_ok) nxt = SELECT;
      end
      SELECT: begin
        syn_d = '0;
        err_d = '0;
        tmo_d = '0;
        if (!bus.cfgen)                nxt = IDLE;
        else if (bus.cfgsettle != '0)  nxt = SETTLE;
        else                           nxt = MEASURE;
      end
      SETTLE: begin
        tmo_d = tmo_next;
        if (!bus.cfgen) begin
          nxt = IDLE;
        end else if (bus.ichksyn) begin
          if (syn_next >= bus.cfgsettle) begin
            nxt   = MEASURE;
            syn_d = '0;
          end else begin
            syn_d = syn_next;
          end
        end else if (tmo_hit) begin
          nxt = REPORT;
          los = 1'b1;
        end
      end
      MEASURE: begin
        tmo_d = tmo_next;
        if (bus.ichkerr) err_d = err_inc;
        if (!bus.cfgen) begin
          nxt = IDLE;
        end else if (bus.ichksyn) begin
          syn_d = syn_next;
          if (syn_next >= dwell_eff) nxt = REPORT;
        end else if (tmo_hit) begin
          nxt = REPORT;
          los = 1'b1;
        end
      end
      REPORT: begin
        nxt = scan_ok ? SELECT : IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      osel_q    <= '0;
      last_q    <= CHW'(NCH - 1);
      syn_cnt   <= '0;
      err_cnt   <= '0;
      tmo_cnt   <= '0;
      ochkrst_q <= 1'b0;
      ordone_q  <= 1'b0;
      obusy_q   <= 1'b0;
      orch_q    <= '0;
      orerr_q   <= '0;
      orlos_q   <= 1'b0;
    end else begin
      state     <= nxt;
      syn_cnt   <= syn_d;
      err_cnt   <= err_d;
      tmo_cnt   <= tmo_d;
      ochkrst_q <= (nxt == SELECT);
      ordone_q  <= (nxt == REPORT);
      obusy_q   <= (nxt != IDLE);
      if (nxt == SELECT) osel_q <= sel_pick;
      // The result record and the round-robin pointer load as REPORT is entered.
      if (nxt == REPORT) begin
        orch_q  <= osel_q;
        orerr_q <= err_d;
        orlos_q <= los;
        last_q  <= osel_q;
      end
    end
  end

  assign bus.osel      = osel_q;
  assign bus.ochkrst   = ochkrst_q;
  assign bus.obusy     = obusy_q;
  assign bus.ordone    = ordone_q;
  assign bus.orch      = orch_q;
  assign bus.orerr     = orerr_q;
  assign bus.orlos     = orlos_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_db_b3chk_sched.sv
// Directed bench for db_b3chk_sched: per-cycle vector table plus hand-written visit sequences.
module tb_db_b3chk_sched;
  localparam int NCH = 4, CHW = 2, ERRW = 4, FRMW = 8;
  localparam logic [2:0] S_IDLE = 3'd0, S_SELECT = 3'd1, S_SETTLE = 3'd2,
                         S_MEASURE = 3'd3, S_REPORT = 3'd4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  db_b3chk_sched_if #(.NCH(NCH), .CHW(CHW), .ERRW(ERRW), .FRMW(FRMW)) bus ();

  db_b3chk_sched #(.NCH(NCH), .CHW(CHW), .ERRW(ERRW), .FRMW(FRMW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       en;
    logic [3:0] mask;
    logic       syn;
    logic       err;
    logic [2:0] st;
    logic       busy;
    logic [1:0] sel;
    logic       chkrst;
    logic       done;
    logic [1:0] rch;
    logic [3:0] rerr;
  } vec_t;

  vec_t tbl[13];
  logic [CHW-1:0] exp_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic e);
    bus.ichksyn = s;
    bus.ichkerr = e;
    step();
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  task automatic do_reset();
    bus.cfgen   = 1'b0;
    bus.ichksyn = 1'b0;
    bus.ichkerr = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string nm);
    int n = 0;
    while (bus.dbg_state != s && n < budget) begin
      drive(1'b0, 1'b0);
      n++;
    end
    chk({nm, " reach state"}, 32'(bus.dbg_state), 32'(s));
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, " state"},   32'(bus.dbg_state), 32'(S_IDLE));
    chk({nm, " osel"},    32'(bus.osel), 0);
    chk({nm, " ochkrst"}, 32'(bus.ochkrst), 0);
    chk({nm, " obusy"},   32'(bus.obusy), 0);
    chk({nm, " ordone"},  32'(bus.ordone), 0);
    chk({nm, " orch"},    32'(bus.orch), 0);
    chk({nm, " orerr"},   32'(bus.orerr), 0);
    chk({nm, " orlos"},   32'(bus.orlos), 0);
  endtask

  initial begin
    int n;
    int dones;
    int overlap;
    int rst_in_visit;
    logic [CHW-1:0] cur_sel;

    //            en  mask     syn  err  st         busy sel   rst  done rch   rerr
    tbl[0]  = '{1'b1, 4'b0000, 1'b0, 1'b0, S_IDLE,    1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0};
    tbl[1]  = '{1'b1, 4'b0100, 1'b0, 1'b0, S_SELECT,  1'b1, 2'd2, 1'b1, 1'b0, 2'd0, 4'd0};
    tbl[2]  = '{1'b1, 4'b0100, 1'b0, 1'b0, S_SETTLE,  1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 4'd0};
    tbl[3]  = '{1'b1, 4'b0100, 1'b1, 1'b1, S_MEASURE, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 4'd0};
    tbl[4]  = '{1'b1, 4'b0100, 1'b0, 1'b1, S_MEASURE, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 4'd0};
    tbl[5]  = '{1'b1, 4'b0100, 1'b1, 1'b1, S_REPORT,  1'b1, 2'd2, 1'b0, 1'b1, 2'd2, 4'd2};
    tbl[6]  = '{1'b1, 4'b0100, 1'b0, 1'b0, S_SELECT,  1'b1, 2'd2, 1'b1, 1'b0, 2'd0, 4'd0};
    tbl[7]  = '{1'b1, 4'b0001, 1'b0, 1'b0, S_SETTLE,  1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 4'd0};
    tbl[8]  = '{1'b1, 4'b0001, 1'b1, 1'b0, S_MEASURE, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 4'd0};
    tbl[9]  = '{1'b1, 4'b0001, 1'b1, 1'b0, S_REPORT,  1'b1, 2'd2, 1'b0, 1'b1, 2'd2, 4'd0};
    tbl[10] = '{1'b1, 4'b0001, 1'b0, 1'b0, S_SELECT,  1'b1, 2'd0, 1'b1, 1'b0, 2'd0, 4'd0};
    tbl[11] = '{1'b0, 4'b0001, 1'b0, 1'b0, S_IDLE,    1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0};
    tbl[12] = '{1'b0, 4'b0001, 1'b0, 1'b0, S_IDLE,    1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0};

    bus.cfgen = 1'b0; bus.cfgchmask = '0; bus.cfgsettle = 8'd1; bus.cfgdwell = 8'd1;
    bus.cfgtmo = 16'd0; bus.ichksyn = 1'b0; bus.ichkerr = 1'b0;

    // Vector table: mask=0 idle, single-channel revisit, deselect mid-visit, abort.
    do_reset();
    chk_reset_outputs("reset");
    for (int i = 0; i < 13; i++) begin
      bus.cfgen = tbl[i].en;
      bus.cfgchmask = tbl[i].mask;
      drive(tbl[i].syn, tbl[i].err);
      chk($sformatf("vec%0d state", i),   32'(bus.dbg_state), 32'(tbl[i].st));
      chk($sformatf("vec%0d obusy", i),   32'(bus.obusy),     32'(tbl[i].busy));
      chk($sformatf("vec%0d osel", i),    32'(bus.osel),      32'(tbl[i].sel));
      chk($sformatf("vec%0d ochkrst", i), 32'(bus.ochkrst),   32'(tbl[i].chkrst));
      chk($sformatf("vec%0d ordone", i),  32'(bus.ordone),    32'(tbl[i].done));
      if (tbl[i].done) begin
        chk($sformatf("vec%0d orch", i),  32'(bus.orch),  32'(tbl[i].rch));
        chk($sformatf("vec%0d orerr", i), 32'(bus.orerr), 32'(tbl[i].rerr));
        chk($sformatf("vec%0d orlos", i), 32'(bus.orlos), 0);
      end
    end

    // Round robin over mask 1011 with sync every 10 cycles.
    do_reset();
    bus.cfgchmask = 4'b1011; bus.cfgsettle = 8'd1; bus.cfgdwell = 8'd2; bus.cfgtmo = 16'd0;
    bus.cfgen = 1'b1;
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd3); exp_q.push_back(2'd0);
    dones = 0; overlap = 0; rst_in_visit = 0; cur_sel = '0;
    for (int cyc = 0; cyc < 1000 && dones < 4; cyc++) begin
      drive((cyc % 10) == 9, 1'b0);
      if (bus.ochkrst && bus.ordone) overlap++;
      if (bus.ochkrst) begin
        rst_in_visit++;
        cur_sel = bus.osel;
        if (exp_q.size() > 0) chk("rr osel", 32'(bus.osel), 32'(exp_q.pop_front()));
        else chk("rr extra select", 32'(exp_q.size()), 1);
      end
      if (bus.ordone) begin
        chk("rr orch", 32'(bus.orch), 32'(cur_sel));
        chk("rr orerr", 32'(bus.orerr), 0);
        chk("rr orlos", 32'(bus.orlos), 0);
        chk("rr ochkrst per visit", 32'(rst_in_visit), 1);
        rst_in_visit = 0;
        dones++;
      end
    end
    chk("rr visits", 32'(dones), 4);
    chk("rr chkrst/done overlap", 32'(overlap), 0);

    // Errors ignored in SETTLE, counted in MEASURE including on the final sync.
    do_reset();
    bus.cfgchmask = 4'b0010; bus.cfgsettle = 8'd2; bus.cfgdwell = 8'd4; bus.cfgen = 1'b1;
    wait_state(S_SETTLE, 10, "err settle");
    chk("err osel", 32'(bus.osel), 1);
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    chk("err enter measure", 32'(bus.dbg_state), 32'(S_MEASURE));
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1);
      drive(1'b1, 1'b0);
    end
    chk("err still measure", 32'(bus.dbg_state), 32'(S_MEASURE));
    drive(1'b1, 1'b1);
    chk("err ordone", 32'(bus.ordone), 1);
    chk("err orch", 32'(bus.orch), 1);
    chk("err orerr", 32'(bus.orerr), 4);
    chk("err orlos", 32'(bus.orlos), 0);

    // Saturation with dwell=0 treated as one sync pulse.
    do_reset();
    bus.cfgchmask = 4'b0001; bus.cfgsettle = 8'd0; bus.cfgdwell = 8'd0; bus.cfgen = 1'b1;
    wait_state(S_MEASURE, 10, "sat");
    for (int i = 0; i < 40; i++) drive(1'b0, 1'b1);
    chk("sat still measure", 32'(bus.dbg_state), 32'(S_MEASURE));
    drive(1'b1, 1'b0);
    chk("sat ordone", 32'(bus.ordone), 1);
    chk("sat orerr", 32'(bus.orerr), 15);

    // Sync timeout of 50 cycles after the first dwell pulse.
    do_reset();
    bus.cfgchmask = 4'b0001; bus.cfgsettle = 8'd0; bus.cfgdwell = 8'd2; bus.cfgtmo = 16'd50;
    bus.cfgen = 1'b1;
    wait_state(S_MEASURE, 10, "tmo");
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b0);
    n = 0;
    while (!bus.ordone && n < 200) begin
      drive(1'b0, 1'b0);
      n++;
    end
    chk("tmo cycles to ordone", 32'(n), 50);
    chk("tmo orlos", 32'(bus.orlos), 1);
    chk("tmo orerr", 32'(bus.orerr), 1);
    chk("tmo state", 32'(bus.dbg_state), 32'(S_REPORT));

    // Timeout disabled: no report, stuck in MEASURE.
    do_reset();
    bus.cfgtmo = 16'd0; bus.cfgen = 1'b1;
    wait_state(S_MEASURE, 10, "notmo");
    drive(1'b1, 1'b0);
    dones = 0;
    for (int i = 0; i < 200; i++) begin
      drive(1'b0, 1'b0);
      if (bus.ordone) dones++;
    end
    chk("notmo ordone count", 32'(dones), 0);
    chk("notmo state", 32'(bus.dbg_state), 32'(S_MEASURE));

    // Abort mid-MEASURE on ch2, then resume on ch2.
    do_reset();
    bus.cfgchmask = 4'b0111; bus.cfgsettle = 8'd0; bus.cfgdwell = 8'd1; bus.cfgen = 1'b1;
    for (int v = 0; v < 2; v++) begin
      wait_state(S_MEASURE, 10, "abort pre");
      drive(1'b1, 1'b0);
      chk("abort pre ordone", 32'(bus.ordone), 1);
      chk("abort pre orch", 32'(bus.orch), 32'(v));
    end
    wait_state(S_MEASURE, 10, "abort ch2");
    chk("abort osel before", 32'(bus.osel), 2);
    bus.cfgen = 1'b0;
    drive(1'b0, 1'b0);
    chk("abort state", 32'(bus.dbg_state), 32'(S_IDLE));
    chk("abort obusy", 32'(bus.obusy), 0);
    chk("abort osel held", 32'(bus.osel), 2);
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0);
      if (bus.ordone) dones++;
    end
    chk("abort no ordone", 32'(dones) + 32'(bus.ordone), 0);
    bus.cfgen = 1'b1;
    drive(1'b0, 1'b0);
    chk("resume state", 32'(bus.dbg_state), 32'(S_SELECT));
    chk("resume osel", 32'(bus.osel), 2);
    chk("resume ochkrst", 32'(bus.ochkrst), 1);

    // Reset in the middle of SETTLE.
    bus.cfgsettle = 8'd3;
    wait_state(S_SETTLE, 10, "midrst");
    rst = 1'b1;
    step();
    chk_reset_outputs("midrst");
    rst = 1'b0;
    bus.cfgen = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/db_b3chk_sched.md
Name: db_b3chk_sched

Overview:
- Time-shares one B3/PRBS checker between NCH line channels.
- Picks the next enabled channel round-robin and drives the select for the upstream data mux.
- Clears the checker, waits for it to settle, then measures errors over a programmed number of frame/sync pulses.
- Emits one result record per channel visit for the error-counter RAM and status logic.

Parameters:
NCH, 4, number of channels scanned
CHW, 2, channel index width (NCH <= 2**CHW)
ERRW, 16, per-visit error counter width
FRMW, 8, settle/dwell frame-count width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfgen  in  1  scan enable
cfgchmask  in  NCH  channel enable mask, bit i = channel i
cfgsettle  in  FRMW  sync pulses ignored after a switch
cfgdwell  in  FRMW  sync pulses measured per visit (0 treated as 1)
cfgtmo  in  16  max clk cycles between sync pulses (0 = no timeout)
ichkerr  in  1  checker error pulse (ob3prbserr)
ichksyn  in  1  checker sync/J1 pulse (oprbssyn)
osel  out  CHW  channel select to data mux
ochkrst  out  1  one-cycle checker clear pulse
obusy  out  1  FSM not in IDLE
ordone  out  1  one-cycle result-valid strobe
orch  out  CHW  channel of result
orerr  out  ERRW  error count of result
orlos  out  1  visit ended by sync timeout

Behaviour:
- Reset: FSM=IDLE; osel=0; ochkrst=0; obusy=0; ordone=0; orch=0; orerr=0; orlos=0; last-channel pointer=NCH-1; all counters=0. Reset mid-visit discards the visit; no ordone.
- All outputs are registered.
- States: IDLE, SELECT, SETTLE, MEASURE, REPORT.
- IDLE -> SELECT when cfgen=1 and cfgchmask!=0. Otherwise stay in IDLE.
- SELECT (exactly 1 cycle):
  - Next channel = first set mask bit searching from last+1 upward, wrapping modulo NCH.
  - osel updates in the SELECT cycle; ochkrst=1 only in that cycle.
  - Next state: SETTLE if cfgsettle!=0, else MEASURE.
  - Sync and frame counters are cleared.
- SETTLE:
  - Counts ichksyn pulses; ichkerr is ignored.
  - When the count reaches cfgsettle, go to MEASURE on the next cycle. The terminating pulse is not counted as a dwell frame.
- MEASURE:
  - ichkerr increments the error counter, saturating at all-ones.
  - Counts ichksyn pulses up to max(cfgdwell,1), then goes to REPORT.
  - An error in the same cycle as the terminating sync is counted.
- Timeout (SETTLE or MEASURE), when cfgtmo!=0:
  - A cycle counter clears on entry and on every ichksyn.
  - When it reaches cfgtmo, go to REPORT with orlos=1.
  - orerr reports the errors accumulated so far (0 if the timeout occurred in SETTLE).
- REPORT (1 cycle):
  - ordone=1; orch=osel; orerr=count; orlos=timeout flag.
  - Update the last pointer to osel.
  - Next state: SELECT if cfgen=1 and mask!=0, else IDLE.
- ordone and ochkrst never assert in the same cycle.
- cfgen falling in SELECT/SETTLE/MEASURE: abort to IDLE next cycle. No ordone; osel holds its value; the last pointer is unchanged.
- cfgchmask and cfg* changes are sampled every cycle. Deselecting the active channel does not abort the visit; the mask takes effect at the next SELECT.
- Single enabled channel: revisited back to back, with ochkrst asserted each visit.
- Throughput: per visit, one SELECT cycle plus one REPORT cycle of overhead beyond the sync-pulse timing.
- obusy=1 in every state except IDLE.

Test Plan:
1. Mask=4'b1011, settle=1, dwell=2, pulses every 10 cycles, no errors -> osel sequence 0,1,3,0; one ordone per visit with orerr=0, orlos=0; ochkrst high exactly once per visit.
2. Ch1 only, settle=2, dwell=4. Inject 1 error during SETTLE, 3 during MEASURE, 1 coincident with the final sync -> orch=1, orerr=4.
3. ERRW=4 build, ichkerr held high for 40 cycles in MEASURE -> orerr=15 (saturated), no wrap.
4. cfgtmo=50, sync stops after the 1st dwell pulse -> ordone exactly 50 cycles after the last pulse with orlos=1. With cfgtmo=0 -> no ordone, FSM stays in MEASURE.
5. cfgen dropped mid-MEASURE on ch2, re-enabled later -> no ordone for ch2; next SELECT picks ch2 again (last pointer unchanged).
6. Mask=0 with cfgen=1 -> obusy=0, no ochkrst. Mask set to 4'b0100 -> SELECT next cycle, osel=2. Reset asserted mid-SETTLE -> all outputs return to reset values next cycle.
